// File: rtl/me_unit_if.sv
// Pipeline stage handshake bundle: valid/allow-in plus a payload bus.
//   master: drives valid and bus, observes allow_in (upstream producer)
//   slave : observes valid and bus, drives allow_in (downstream consumer)
interface me_unit_if #(
  parameter int unsigned Width = 32
) ();
  logic             valid;
  logic             allow_in;
  logic [Width-1:0] bus;

  modport master (output valid, output bus, input allow_in);
  modport slave  (input valid, input bus, output allow_in);
endinterface

// File: rtl/me_unit.sv
// Memory-access stage of the LoongArch pipeline.
// Latches the EX->ME bus, aligns and extends load data coming back from the
// synchronous data SRAM, forwards its result to decode and hands the result
// bus to write-back. A hold buffer keeps load data while write-back stalls.
// Ports:
//   clk, resetn      clock, asynchronous active-low reset
//   ex_me (slave)    EX_to_ME valid / bus (78b) in, ME_Allow_in out
//   me_wb (master)   ME_to_WB valid / bus (72b) out, WB_Allow_in in
//   data_sram_rdata  SRAM read data, valid in the first ME cycle only
//   ME_dest          forwarding destination (0 when not writing)
//   ME_Forward_Res   final result for forwarding
//   excp_flush, ertn_flush  pipeline flush requests
module me_unit #(
  parameter int unsigned EX_to_ME_Bus_Size = 78,
  parameter int unsigned ME_to_WB_Bus_Size = 72
) (
  input  logic        clk,
  input  logic        resetn,
  me_unit_if.slave    ex_me,
  me_unit_if.master   me_wb,
  input  logic [31:0] data_sram_rdata,
  output logic [4:0]  ME_dest,
  output logic [31:0] ME_Forward_Res,
  input  logic        excp_flush,
  input  logic        ertn_flush
);

  logic                         me_valid_q;
  logic [EX_to_ME_Bus_Size-1:0] bus_q;
  logic [31:0]                  rdata_held_q;
  logic                         hold_vld_q;

  logic flush;
  logic allow_in;
  logic capture;
  logic hold_load;

  // Latched bus fields
  logic        syscall;
  logic        ertn;
  logic        is_signed;
  logic        is_byte;
  logic        is_half;
  logic [1:0]  offset;
  logic [31:0] pc;
  logic [31:0] result;
  logic        res_from_mem;
  logic        gr_we;
  logic [4:0]  dest;

  assign syscall      = bus_q[77];
  assign ertn         = bus_q[76];
  assign is_signed    = bus_q[75];
  assign is_byte      = bus_q[74];
  assign is_half      = bus_q[73];
  assign offset       = bus_q[72:71];
  assign pc           = bus_q[70:39];
  assign result       = bus_q[38:7];
  assign res_from_mem = bus_q[6];
  assign gr_we        = bus_q[5];
  assign dest         = bus_q[4:0];

  assign flush    = excp_flush | ertn_flush;
  // Ready-go is always 1, so the stage only blocks on a write-back stall.
  assign allow_in = ~me_valid_q | me_wb.allow_in;
  assign capture  = allow_in & ex_me.valid;
  // SRAM data is only valid in the first ME cycle; grab it if we are about to stall.
  assign hold_load = me_valid_q & ~hold_vld_q & ~me_wb.allow_in;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      me_valid_q   <= 1'b0;
      bus_q        <= '0;
      rdata_held_q <= 32'h0;
      hold_vld_q   <= 1'b0;
    end else begin
      if (flush) begin
        me_valid_q <= 1'b0;
      end else if (allow_in) begin
        me_valid_q <= ex_me.valid;
      end

      if (capture) begin
        bus_q <= ex_me.bus;
      end

      if (capture || flush) begin
        hold_vld_q <= 1'b0;
      end else if (hold_load) begin
        hold_vld_q <= 1'b1;
      end

      if (hold_load) begin
        rdata_held_q <= data_sram_rdata;
      end
    end
  end

  logic [31:0] load_word;
  logic [7:0]  mem_byte;
  logic [15:0] mem_half;
  logic [31:0] loaded;
  logic [31:0] final_res;

  always_comb begin
    load_word = hold_vld_q ? rdata_held_q : data_sram_rdata;
    mem_byte  = 8'h00;
    unique case (offset)
      2'd0: mem_byte = load_word[7:0];
      2'd1: mem_byte = load_word[15:8];
      2'd2: mem_byte = load_word[23:16];
      2'd3: mem_byte = load_word[31:24];
    endcase
    mem_half = offset[1] ? load_word[31:16] : load_word[15:0];
    if (is_byte) begin
      loaded = {{24{is_signed & mem_byte[7]}}, mem_byte};
    end else if (is_half) begin
      loaded = {{16{is_signed & mem_half[15]}}, mem_half};
    end else begin
      loaded = load_word;
    end
    final_res = res_from_mem ? loaded : result;
  end

  logic [ME_to_WB_Bus_Size-1:0] wb_bus;
  assign wb_bus = {syscall, ertn, pc, final_res, gr_we, dest};

  assign ex_me.allow_in = allow_in;
  assign me_wb.valid    = me_valid_q;
  assign me_wb.bus      = wb_bus;
  assign ME_dest        = (me_valid_q & gr_we) ? dest : 5'd0;
  assign ME_Forward_Res = final_res;

endmodule

// File: tb/tb_me_unit.sv
// Self-checking bench for me_unit: directed vector table, hand-written
// stall/flush/reset sequences and randomized traffic against a reference model.
module tb_me_unit;

  logic        clk;
  logic        resetn;
  logic [31:0] rdata;
  logic [4:0]  me_dest;
  logic [31:0] fwd_res;
  logic        excp_flush;
  logic        ertn_flush;

  me_unit_if #(.Width(78)) ex_me ();
  me_unit_if #(.Width(72)) me_wb ();

  me_unit dut (
    .clk             (clk),
    .resetn          (resetn),
    .ex_me           (ex_me),
    .me_wb           (me_wb),
    .data_sram_rdata (rdata),
    .ME_dest         (me_dest),
    .ME_Forward_Res  (fwd_res),
    .excp_flush      (excp_flush),
    .ertn_flush      (ertn_flush)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  int n_vec  = 0;
  int n_miss = 0;

  task automatic chk(input string name, input logic [77:0] act, input logic [77:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [77:0] mk_bus(input logic sys, input logic er, input logic sgn,
                                         input logic byt, input logic half,
                                         input logic [1:0] off, input logic [31:0] pc,
                                         input logic [31:0] res, input logic rfm,
                                         input logic we, input logic [4:0] dest);
    return {sys, er, sgn, byt, half, off, pc, res, rfm, we, dest};
  endfunction

  // Load alignment from the architectural rules, with plain arithmetic.
  function automatic logic [31:0] ref_load(input logic [31:0] word, input logic sgn,
                                           input logic byt, input logic half,
                                           input logic [1:0] off);
    int unsigned o;
    logic [31:0] v;
    o = off;
    if (byt) begin
      v = (word >> (8 * o)) & 32'hFF;
      if (sgn && v >= 32'd128) v = v | 32'hFFFF_FF00;
    end else if (half) begin
      v = (word >> (16 * (o / 2))) & 32'hFFFF;
      if (sgn && v >= 32'd32768) v = v | 32'hFFFF_0000;
    end else begin
      v = word;
    end
    return v;
  endfunction

  // Reference model: the instruction occupying the stage, whether this is its
  // first cycle there, and the word it saw in that first cycle.
  logic        m_valid;
  logic [77:0] m_bus;
  logic        m_first;
  logic [31:0] m_word;

  task automatic model_reset();
    m_valid = 1'b0;
    m_bus   = '0;
    m_first = 1'b0;
    m_word  = 32'h0;
  endtask

  task automatic model_check();
    logic        exp_allow;
    logic [4:0]  exp_dest;
    logic [31:0] word;
    logic [31:0] fin;
    exp_allow = !m_valid || me_wb.allow_in;
    chk("allow_in", {77'd0, ex_me.allow_in}, {77'd0, exp_allow});
    chk("wb_valid", {77'd0, me_wb.valid}, {77'd0, m_valid});
    exp_dest = (m_valid && m_bus[5]) ? m_bus[4:0] : 5'd0;
    chk("me_dest", {73'd0, me_dest}, {73'd0, exp_dest});
    if (m_valid) begin
      word = m_first ? rdata : m_word;
      fin  = m_bus[6] ? ref_load(word, m_bus[75], m_bus[74], m_bus[73], m_bus[72:71])
                      : m_bus[38:7];
      chk("wb_bus", {6'd0, me_wb.bus}, {6'd0, m_bus[77:76], m_bus[70:39], fin, m_bus[5:0]});
      chk("fwd_res", {46'd0, fwd_res}, {46'd0, fin});
    end
  endtask

  task automatic model_update();
    logic acc;
    acc = !m_valid || me_wb.allow_in;
    if (m_valid && !acc) begin
      if (m_first) m_word = rdata;
      m_first = 1'b0;
    end
    if (acc && ex_me.valid) begin
      m_bus   = ex_me.bus;
      m_first = 1'b1;
    end
    if (excp_flush || ertn_flush) m_valid = 1'b0;
    else if (acc) m_valid = ex_me.valid;
  endtask

  // Inputs are driven just after a rising edge; outputs checked at the falling edge.
  task automatic half_a();
    @(negedge clk);
    model_check();
  endtask

  task automatic half_b();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic idle_inputs();
    ex_me.valid    = 1'b0;
    ex_me.bus      = '0;
    me_wb.allow_in = 1'b1;
    excp_flush     = 1'b0;
    ertn_flush     = 1'b0;
    rdata          = 32'h0;
  endtask

  typedef struct packed {
    logic        sgn;
    logic        byt;
    logic        half;
    logic [1:0]  off;
    logic        rfm;
    logic        we;
    logic [4:0]  dest;
    logic [31:0] res;
    logic [31:0] rdata;
    logic [31:0] exp_res;
    logic [4:0]  exp_dest;
  } vec_t;

  vec_t vecs [10];

  initial begin
    // sgn byt half off rfm we dest res rdata exp_res exp_dest
    vecs[0] = '{1'b1, 1'b1, 1'b0, 2'd3, 1'b1, 1'b1, 5'd5, 32'h0, 32'h80FF1234, 32'hFFFFFF80, 5'd5};
    vecs[1] = '{1'b0, 1'b0, 1'b1, 2'd2, 1'b1, 1'b1, 5'd6, 32'h0, 32'hBEEF0001, 32'h0000BEEF, 5'd6};
    vecs[2] = '{1'b0, 1'b1, 1'b0, 2'd1, 1'b1, 1'b1, 5'd8, 32'h0, 32'h80FF1234, 32'h00000012, 5'd8};
    vecs[3] = '{1'b1, 1'b1, 1'b0, 2'd2, 1'b1, 1'b1, 5'd9, 32'h0, 32'h80FF1234, 32'hFFFFFFFF, 5'd9};
    vecs[4] = '{1'b1, 1'b0, 1'b1, 2'd0, 1'b1, 1'b1, 5'd10, 32'h0, 32'h12348001, 32'hFFFF8001, 5'd10};
    vecs[5] = '{1'b1, 1'b0, 1'b1, 2'd3, 1'b1, 1'b1, 5'd11, 32'h0, 32'h87654321, 32'hFFFF8765, 5'd11};
    vecs[6] = '{1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 1'b1, 5'd12, 32'h0, 32'hCAFEF00D, 32'hCAFEF00D, 5'd12};
    vecs[7] = '{1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b1, 5'd7, 32'h42, 32'hFFFFFFFF, 32'h00000042, 5'd7};
    vecs[8] = '{1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 5'd7, 32'h42, 32'h0, 32'h00000042, 5'd0};
    vecs[9] = '{1'b0, 1'b1, 1'b0, 2'd0, 1'b1, 1'b1, 5'd31, 32'h0, 32'h000000FF, 32'h000000FF, 5'd31};

    idle_inputs();
    resetn = 1'b0;
    model_reset();
    #12;
    chk("rst_allow_in", {77'd0, ex_me.allow_in}, 78'd1);
    chk("rst_wb_valid", {77'd0, me_wb.valid}, 78'd0);
    chk("rst_me_dest", {73'd0, me_dest}, 78'd0);
    chk("rst_wb_bus", {6'd0, me_wb.bus}, 78'd0);
    @(posedge clk);
    #1;
    resetn = 1'b1;

    // Directed vector table: capture, then check the result one cycle later.
    for (int i = 0; i < 10; i++) begin
      ex_me.valid    = 1'b1;
      ex_me.bus      = mk_bus(1'b0, 1'b0, vecs[i].sgn, vecs[i].byt, vecs[i].half, vecs[i].off,
                              32'h1C00_0000 + 32'(i * 4), vecs[i].res, vecs[i].rfm, vecs[i].we,
                              vecs[i].dest);
      me_wb.allow_in = 1'b1;
      rdata          = $urandom;
      half_a();
      half_b();
      ex_me.valid = 1'b0;
      rdata       = vecs[i].rdata;
      half_a();
      chk("vec_valid", {77'd0, me_wb.valid}, 78'd1);
      chk("vec_result", {46'd0, fwd_res}, {46'd0, vecs[i].exp_res});
      chk("vec_dest", {73'd0, me_dest}, {73'd0, vecs[i].exp_dest});
      chk("vec_pc", {46'd0, me_wb.bus[69:38]}, {46'd0, 32'h1C00_0000 + 32'(i * 4)});
      half_b();
    end

    // ld.w held across a 3-cycle write-back stall; a second offer must wait.
    ex_me.valid = 1'b1;
    ex_me.bus   = mk_bus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 32'h1C00_1000, 32'h0,
                         1'b1, 1'b1, 5'd9);
    half_a();
    half_b();
    ex_me.bus      = mk_bus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 32'h1C00_1004, 32'h55,
                            1'b0, 1'b1, 5'd3);
    me_wb.allow_in = 1'b0;
    for (int c = 0; c < 3; c++) begin
      rdata = (c == 0) ? 32'h12345678 : 32'hDEADBEEF;
      half_a();
      chk("stall_result", {46'd0, fwd_res}, {46'd0, 32'h12345678});
      chk("stall_allow_in", {77'd0, ex_me.allow_in}, 78'd0);
      chk("stall_dest", {73'd0, me_dest}, 78'd9);
      half_b();
    end
    ex_me.valid    = 1'b0;
    me_wb.allow_in = 1'b1;
    half_a();
    chk("release_result", {46'd0, fwd_res}, {46'd0, 32'h12345678});
    chk("release_allow_in", {77'd0, ex_me.allow_in}, 78'd1);
    half_b();
    half_a();
    chk("after_release_valid", {77'd0, me_wb.valid}, 78'd0);
    half_b();

    // Flush in the same cycle as the capture, for each flush source.
    for (int f = 0; f < 2; f++) begin
      ex_me.valid = 1'b1;
      ex_me.bus   = mk_bus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 32'h1C00_2000, 32'h77,
                           1'b0, 1'b1, 5'd3);
      excp_flush  = (f == 0);
      ertn_flush  = (f == 1);
      half_a();
      half_b();
      ex_me.valid = 1'b0;
      excp_flush  = 1'b0;
      ertn_flush  = 1'b0;
      half_a();
      chk("flush_valid", {77'd0, me_wb.valid}, 78'd0);
      chk("flush_dest", {73'd0, me_dest}, 78'd0);
      half_b();
    end

    // Reset during a stalled load, then a fresh load must not see stale data.
    ex_me.valid = 1'b1;
    ex_me.bus   = mk_bus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 32'h1C00_3000, 32'h0,
                         1'b1, 1'b1, 5'd4);
    half_a();
    half_b();
    ex_me.valid    = 1'b0;
    me_wb.allow_in = 1'b0;
    rdata          = 32'h11112222;
    half_a();
    half_b();
    #2;
    resetn = 1'b0;
    #1;
    chk("midrst_allow_in", {77'd0, ex_me.allow_in}, 78'd1);
    chk("midrst_valid", {77'd0, me_wb.valid}, 78'd0);
    chk("midrst_dest", {73'd0, me_dest}, 78'd0);
    chk("midrst_bus", {6'd0, me_wb.bus}, 78'd0);
    model_reset();
    @(posedge clk);
    #1;
    resetn = 1'b1;
    ex_me.valid = 1'b1;
    ex_me.bus   = mk_bus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 32'h1C00_4000, 32'h0,
                         1'b1, 1'b1, 5'd2);
    half_a();
    half_b();
    ex_me.valid = 1'b0;
    rdata       = 32'hCAFEF00D;
    half_a();
    chk("post_rst_result", {46'd0, fwd_res}, {46'd0, 32'hCAFEF00D});
    half_b();
    rdata = 32'h0BAD0BAD;
    half_a();
    chk("post_rst_held", {46'd0, fwd_res}, {46'd0, 32'hCAFEF00D});
    me_wb.allow_in = 1'b1;
    half_b();

    // Randomized traffic against the reference model.
    for (int n = 0; n < 400; n++) begin
      int unsigned sel;
      sel            = $urandom_range(0, 2);
      ex_me.valid    = ($urandom_range(0, 3) != 0);
      ex_me.bus      = mk_bus(1'($urandom), 1'($urandom), 1'($urandom), sel == 0, sel == 1,
                              2'($urandom), $urandom, $urandom, ($urandom_range(0, 3) != 0),
                              1'($urandom), 5'($urandom));
      me_wb.allow_in = ($urandom_range(0, 9) < 7);
      excp_flush     = ($urandom_range(0, 29) == 0);
      ertn_flush     = ($urandom_range(0, 29) == 0);
      rdata          = $urandom;
      half_a();
      half_b();
    end

    idle_inputs();
    half_a();
    half_b();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
